// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: state encoding,
// opcode/funct constants and ALU operation codes used by the ALU and datapath.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC     = 4'd2,
    S_R_WB     = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // States that wait on mem_ready and are covered by the timeout counter.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control <-> datapath/ALU/memory bundle. master = controller, slave = datapath side.
// Handshake: the controller holds its memory strobes stable while waiting; an
// access completes in any cycle where a memory state sees mem_ready=1.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       notzero;
  logic       mem_ready;
  logic [3:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_source;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal_op;
  logic       err_timeout;
  logic [3:0] state_o;

  modport master (
    input  opcode, funct, zero, notzero, mem_ready,
    output alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
           pc_write, pc_source, reg_write, reg_dst, mem_to_reg, illegal_op,
           err_timeout, state_o
  );

  modport slave (
    output opcode, funct, zero, notzero, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
           pc_write, pc_source, reg_write, reg_dst, mem_to_reg, illegal_op,
           err_timeout, state_o
  );
endinterface

// File: rtl/mips_funct_decode.sv
// R-type funct field to ALU operation; valid=0 flags an unsupported funct.
module mips_funct_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       valid
);

  always_comb begin
    alu_op = ALU_ADD;
    valid  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      FN_NOR:  alu_op = ALU_NOR;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM. Define MIPS_BNE_EN to add bne (opcode 000101);
// without it bne decodes as an illegal opcode.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  mips_multicycle_ctrl_if.master bus
);

  localparam int CW = (FETCH_TIMEOUT < 15) ? 4 : $clog2(FETCH_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX  = CW'(FETCH_TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'((FETCH_TIMEOUT > 0) ? FETCH_TIMEOUT - 1 : 0);

  state_t        state, state_next, decode_next;
  logic [CW-1:0] wait_cnt;
  logic [3:0]    funct_alu_op;
  logic          funct_valid;
  logic          op_illegal;
  logic          branch_taken;
  logic          timeout_hit;

  mips_funct_decode u_funct_decode (
    .funct  (bus.funct),
    .alu_op (funct_alu_op),
    .valid  (funct_valid)
  );

  always_comb begin
    decode_next = S_FETCH;
    case (bus.opcode)
      OP_RTYPE:     decode_next = S_EXEC;
      OP_LW, OP_SW: decode_next = S_MEM_ADDR;
      OP_BEQ:       decode_next = S_BRANCH;
`ifdef MIPS_BNE_EN
      OP_BNE:       decode_next = S_BRANCH;
`endif
      OP_J:         decode_next = S_JUMP;
      OP_ADDI:      decode_next = S_ADDI_EX;
      default:      decode_next = S_FETCH;
    endcase
  end

  assign op_illegal = (decode_next == S_FETCH);
  // bne can only reach BRANCH when it is enabled, so this select is safe in both builds.
  assign branch_taken = (bus.opcode == OP_BNE) ? bus.notzero : bus.zero;
  assign timeout_hit  = (FETCH_TIMEOUT != 0) && is_mem_state(state) && !bus.mem_ready
                        && (wait_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  // Saturating wait counter, cleared whenever the state changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wait_cnt <= '0;
    else if (state_next != state) wait_cnt <= '0;
    else if (is_mem_state(state) && !bus.mem_ready && (wait_cnt != TO_MAX))
      wait_cnt <= wait_cnt + 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    state_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   state_next = decode_next;
      S_EXEC:     state_next = funct_valid ? S_R_WB : S_FETCH;
      S_R_WB:     state_next = S_FETCH;
      S_MEM_ADDR: state_next = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_next = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   state_next = S_FETCH;
      S_MEM_WR:   state_next = bus.mem_ready ? S_FETCH : S_MEM_WR;
      S_BRANCH:   state_next = S_FETCH;
      S_JUMP:     state_next = S_FETCH;
      S_ADDI_EX:  state_next = S_ADDI_WB;
      S_ADDI_WB:  state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  // Everything is forced to its idle value while reset is held.
  always_comb begin
    bus.alu_op      = ALU_ADD;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = 2'b00;
    bus.iord        = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.ir_write    = 1'b0;
    bus.pc_write    = 1'b0;
    bus.pc_source   = 2'b00;
    bus.reg_write   = 1'b0;
    bus.reg_dst     = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.illegal_op  = 1'b0;
    bus.err_timeout = 1'b0;
    bus.state_o     = state;
    if (rst_n) begin
      bus.err_timeout = timeout_hit;
      case (state)
        S_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        S_DECODE: begin
          bus.alu_src_b  = 2'b11;
          bus.illegal_op = op_illegal;
        end
        S_EXEC: begin
          bus.alu_src_a  = 1'b1;
          bus.alu_op     = funct_alu_op;
          bus.illegal_op = !funct_valid;
        end
        S_R_WB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 1'b1;
        end
        S_MEM_ADDR, S_ADDI_EX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          bus.iord     = 1'b1;
          bus.mem_read = 1'b1;
        end
        S_MEM_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          bus.iord      = 1'b1;
          bus.mem_write = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = ALU_SUB;
          bus.pc_source = 2'b01;
          bus.pc_write  = branch_taken;
        end
        S_JUMP: begin
          bus.pc_source = 2'b10;
          bus.pc_write  = 1'b1;
        end
        S_ADDI_WB: bus.reg_write = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: one task per instruction class or
// scenario, expected values written out by hand.
module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   tests  = 0;
  int   failed = 0;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl #(.FETCH_TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.opcode = 6'b000000; bus.funct = 6'b100000;
    bus.zero = 1'b0; bus.notzero = 1'b0; bus.mem_ready = 1'b1;
    tick(); tick();
    tests++; if (bus.state_o !== 4'd0) begin failed++; $display("FAIL reset_state: got %0d expected 0", bus.state_o); end
    tests++; if ({bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write, bus.reg_write} !== 5'b0) begin
      failed++; $display("FAIL reset_strobes: got %b expected 00000", {bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write, bus.reg_write}); end
    tests++; if (bus.alu_op !== 4'b0010 || bus.alu_src_b !== 2'b00 || bus.illegal_op !== 1'b0 || bus.err_timeout !== 1'b0) begin
      failed++; $display("FAIL reset_selects: alu_op %b src_b %b ill %b to %b expected 0010 00 0 0", bus.alu_op, bus.alu_src_b, bus.illegal_op, bus.err_timeout); end
    rst_n = 1'b1;
    #1;
    tests++; if (bus.mem_read !== 1'b1 || bus.alu_src_b !== 2'b01 || bus.iord !== 1'b0 || bus.alu_src_a !== 1'b0) begin
      failed++; $display("FAIL fetch_outputs: mem_read %b src_b %b iord %b src_a %b expected 1 01 0 0", bus.mem_read, bus.alu_src_b, bus.iord, bus.alu_src_a); end
  endtask

  task automatic test_rtype();
    bus.opcode = 6'b000000; bus.funct = 6'b100010; bus.mem_ready = 1'b1;
    #1;
    tests++; if (bus.ir_write !== 1'b1 || bus.pc_write !== 1'b1) begin
      failed++; $display("FAIL rtype_fetch_done: ir_write %b pc_write %b expected 1 1", bus.ir_write, bus.pc_write); end
    tick();
    tests++; if (bus.state_o !== 4'd1 || bus.alu_src_b !== 2'b11 || bus.alu_src_a !== 1'b0) begin
      failed++; $display("FAIL rtype_decode: state %0d src_b %b src_a %b expected 1 11 0", bus.state_o, bus.alu_src_b, bus.alu_src_a); end
    tick();
    tests++; if (bus.state_o !== 4'd2 || bus.alu_op !== 4'b0110 || bus.alu_src_a !== 1'b1 || bus.alu_src_b !== 2'b00) begin
      failed++; $display("FAIL rtype_exec: state %0d alu_op %b src_a %b src_b %b expected 2 0110 1 00", bus.state_o, bus.alu_op, bus.alu_src_a, bus.alu_src_b); end
    tick();
    tests++; if (bus.state_o !== 4'd3 || bus.reg_write !== 1'b1 || bus.reg_dst !== 1'b1 || bus.mem_to_reg !== 1'b0) begin
      failed++; $display("FAIL rtype_wb: state %0d rw %b rd %b m2r %b expected 3 1 1 0", bus.state_o, bus.reg_write, bus.reg_dst, bus.mem_to_reg); end
    tick();
    tests++; if (bus.state_o !== 4'd0) begin failed++; $display("FAIL rtype_latency: got state %0d expected 0", bus.state_o); end
  endtask

  task automatic test_lw_stall();
    logic held_ok;
    bus.opcode = 6'b100011; bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;  // ignored outside memory states
    tick();
    tests++; if (bus.state_o !== 4'd4 || bus.alu_src_a !== 1'b1 || bus.alu_src_b !== 2'b10 || bus.alu_op !== 4'b0010) begin
      failed++; $display("FAIL lw_mem_addr: state %0d src_a %b src_b %b alu_op %b expected 4 1 10 0010", bus.state_o, bus.alu_src_a, bus.alu_src_b, bus.alu_op); end
    tick();
    held_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (bus.state_o !== 4'd5 || bus.mem_read !== 1'b1 || bus.iord !== 1'b1 || bus.reg_write !== 1'b0) held_ok = 1'b0;
      tick();
    end
    tests++; if (held_ok !== 1'b1) begin failed++; $display("FAIL lw_wait_hold: got %b expected 1", held_ok); end
    tests++; if (bus.state_o !== 4'd5 || bus.mem_read !== 1'b1) begin
      failed++; $display("FAIL lw_still_waiting: state %0d mem_read %b expected 5 1", bus.state_o, bus.mem_read); end
    bus.mem_ready = 1'b1;
    tick();
    tests++; if (bus.state_o !== 4'd6 || bus.reg_write !== 1'b1 || bus.reg_dst !== 1'b0 || bus.mem_to_reg !== 1'b1) begin
      failed++; $display("FAIL lw_wb: state %0d rw %b rd %b m2r %b expected 6 1 0 1", bus.state_o, bus.reg_write, bus.reg_dst, bus.mem_to_reg); end
    tick();
    tests++; if (bus.state_o !== 4'd0) begin failed++; $display("FAIL lw_return: got state %0d expected 0", bus.state_o); end
  endtask

  task automatic test_sw();
    bus.opcode = 6'b101011; bus.mem_ready = 1'b1;
    tick(); tick(); tick();
    tests++; if (bus.state_o !== 4'd7 || bus.mem_write !== 1'b1 || bus.iord !== 1'b1 || bus.mem_read !== 1'b0) begin
      failed++; $display("FAIL sw_mem_wr: state %0d mw %b iord %b mr %b expected 7 1 1 0", bus.state_o, bus.mem_write, bus.iord, bus.mem_read); end
    tick();
    tests++; if (bus.state_o !== 4'd0) begin failed++; $display("FAIL sw_latency: got state %0d expected 0", bus.state_o); end
  endtask

  task automatic test_beq(input logic z);
    bus.opcode = 6'b000100; bus.zero = z; bus.notzero = ~z; bus.mem_ready = 1'b1;
    tick(); tick();
    tests++; if (bus.state_o !== 4'd8 || bus.pc_write !== z || bus.pc_source !== 2'b01 || bus.alu_op !== 4'b0110) begin
      failed++; $display("FAIL beq_branch_z%0d: state %0d pcw %b pcs %b alu_op %b expected 8 %b 01 0110", z, bus.state_o, bus.pc_write, bus.pc_source, bus.alu_op, z); end
    tick();
    tests++; if (bus.state_o !== 4'd0) begin failed++; $display("FAIL beq_latency: got state %0d expected 0", bus.state_o); end
    bus.zero = 1'b0; bus.notzero = 1'b0;
  endtask

  task automatic test_bne();
    bus.opcode = 6'b000101; bus.zero = 1'b0; bus.notzero = 1'b1; bus.mem_ready = 1'b1;
    tick();
`ifdef MIPS_BNE_EN
    tick();
    tests++; if (bus.state_o !== 4'd8 || bus.pc_write !== 1'b1 || bus.pc_source !== 2'b01) begin
      failed++; $display("FAIL bne_taken: state %0d pcw %b pcs %b expected 8 1 01", bus.state_o, bus.pc_write, bus.pc_source); end
`else
    tests++; if (bus.state_o !== 4'd1 || bus.illegal_op !== 1'b1) begin
      failed++; $display("FAIL bne_illegal: state %0d ill %b expected 1 1", bus.state_o, bus.illegal_op); end
`endif
    tick();
    tests++; if (bus.state_o !== 4'd0 || bus.illegal_op !== 1'b0) begin
      failed++; $display("FAIL bne_return: state %0d ill %b expected 0 0", bus.state_o, bus.illegal_op); end
    bus.notzero = 1'b0;
  endtask

  task automatic test_jump_addi();
    bus.opcode = 6'b000010; bus.mem_ready = 1'b1;
    tick(); tick();
    tests++; if (bus.state_o !== 4'd9 || bus.pc_write !== 1'b1 || bus.pc_source !== 2'b10) begin
      failed++; $display("FAIL jump: state %0d pcw %b pcs %b expected 9 1 10", bus.state_o, bus.pc_write, bus.pc_source); end
    tick();
    bus.opcode = 6'b001000;
    tick(); tick();
    tests++; if (bus.state_o !== 4'd10 || bus.alu_src_a !== 1'b1 || bus.alu_src_b !== 2'b10 || bus.alu_op !== 4'b0010) begin
      failed++; $display("FAIL addi_ex: state %0d src_a %b src_b %b alu_op %b expected 10 1 10 0010", bus.state_o, bus.alu_src_a, bus.alu_src_b, bus.alu_op); end
    tick();
    tests++; if (bus.state_o !== 4'd11 || bus.reg_write !== 1'b1 || bus.reg_dst !== 1'b0 || bus.mem_to_reg !== 1'b0) begin
      failed++; $display("FAIL addi_wb: state %0d rw %b rd %b m2r %b expected 11 1 0 0", bus.state_o, bus.reg_write, bus.reg_dst, bus.mem_to_reg); end
    tick();
  endtask

  task automatic test_illegal();
    bus.opcode = 6'b000000; bus.funct = 6'b000000; bus.mem_ready = 1'b1;
    tick(); tick();
    tests++; if (bus.state_o !== 4'd2 || bus.illegal_op !== 1'b1 || bus.reg_write !== 1'b0) begin
      failed++; $display("FAIL bad_funct: state %0d ill %b rw %b expected 2 1 0", bus.state_o, bus.illegal_op, bus.reg_write); end
    tick();
    tests++; if (bus.state_o !== 4'd0 || bus.reg_write !== 1'b0) begin
      failed++; $display("FAIL bad_funct_return: state %0d rw %b expected 0 0", bus.state_o, bus.reg_write); end
    bus.opcode = 6'b111111; bus.funct = 6'b100000;
    tick();
    tests++; if (bus.illegal_op !== 1'b1) begin failed++; $display("FAIL bad_opcode: ill %b expected 1", bus.illegal_op); end
    tick();
    tests++; if (bus.state_o !== 4'd0) begin failed++; $display("FAIL bad_opcode_return: got state %0d expected 0", bus.state_o); end
  endtask

  task automatic test_timeout();
    int pulses = 0;
    int pulse_at = 0;
    logic stayed = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    for (int i = 1; i <= 20; i++) begin
      if (bus.err_timeout === 1'b1) begin pulses++; pulse_at = i; end
      if (bus.state_o !== 4'd0 || bus.mem_read !== 1'b1) stayed = 1'b0;
      tick();
    end
    tests++; if (pulses != 1 || pulse_at != 16) begin
      failed++; $display("FAIL timeout_pulse: %0d pulses at cycle %0d expected 1 at 16", pulses, pulse_at); end
    tests++; if (stayed !== 1'b1) begin failed++; $display("FAIL timeout_wait: stayed %b expected 1", stayed); end
  endtask

  task automatic test_reset_mid_memwr();
    bus.opcode = 6'b101011; bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    tick(); tick(); tick();
    tests++; if (bus.state_o !== 4'd7 || bus.mem_write !== 1'b1) begin
      failed++; $display("FAIL memwr_wait: state %0d mw %b expected 7 1", bus.state_o, bus.mem_write); end
    #1 rst_n = 1'b0;
    #1;
    tests++; if (bus.state_o !== 4'd0 || bus.mem_write !== 1'b0 || bus.reg_write !== 1'b0 || bus.mem_read !== 1'b0) begin
      failed++; $display("FAIL reset_mid_memwr: state %0d mw %b rw %b mr %b expected 0 0 0 0", bus.state_o, bus.mem_write, bus.reg_write, bus.mem_read); end
    @(negedge clk);
    rst_n = 1'b1; bus.mem_ready = 1'b1;
    #1;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_sw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_bne();
    test_jump_addi();
    test_illegal();
    test_timeout();
    test_reset_mid_memwr();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
